ps2_key_ctrl: RTL and testbench



---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_event_fifo.sv | 70 +++++++
 rtl/ps2_key_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Scan-code byte constants, decoder states and event record.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] c_byte_e0 = 8'hE0;
  localparam logic [7:0] c_byte_f0 = 8'hF0;
  localparam logic [7:0] c_byte_e1 = 8'hE1;
  localparam logic [7:0] c_byte_aa = 8'hAA;
  localparam logic [7:0] c_byte_fc = 8'hFC;
  localparam logic [7:0] c_byte_12 = 8'h12;
  localparam logic [7:0] c_byte_00 = 8'h00;
  localparam logic [7:0] c_byte_ff = 8'hFF;

  // Bytes that follow E1 in the pause sequence before the event is emitted
  localparam logic [2:0] c_pause_skip = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E0   = 3'd1,
    ST_F0   = 3'd2,
    ST_E0F0 = 3'd3,
    ST_SKIP = 3'd4
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  function automatic ps2_event_t mk_event(input logic [7:0] code, input logic ext,
                                          input logic brk);
    ps2_event_t ev;
    ev.code = code;
    ev.ext  = ext;
    ev.brk  = brk;
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_event_fifo
// Brief    : Show-ahead key-event FIFO; head output holds the last popped entry
//            while empty. Revision : 1.0
// ============================================================================
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  ps2_event_t data_i,
  input  logic       pop_i,
  output ps2_event_t data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ps2_event_t      mem_q [DEPTH];
  ps2_event_t      last_q;
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [AW:0]     cnt_q;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign w_pop   = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a push while full still lands
  assign w_push  = push_i && (!full_o || w_pop);
  assign drop_o  = push_i && full_o && !w_pop;
  assign data_o  = empty_o ? last_q : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (w_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (w_pop) begin
        rd_q   <= rd_q + AW'(1);
        last_q <= mem_q[rd_q];
      end
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Brief    : PS/2 scan-code sequencer producing make/break events, with BAT
//            status, error statistics and receiver resync. Revision : 1.0
// ============================================================================
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_VALID,
  input  logic [7:0] RX_DATA,
  input  logic       RX_ERR,
  output logic       RX_RST,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [7:0] EV_CODE,
  output logic       EV_EXT,
  output logic       EV_BREAK,
  output logic       KB_OK,
  output logic       KB_FAIL,
  output logic [7:0] ERR_CNT,
  output logic       OVF
);

  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e        state_q, state_d;
  logic [2:0]        skip_q, skip_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              kb_ok_q, kb_ok_d;
  logic              kb_fail_q, kb_fail_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              ovf_q;
  logic              rx_rst_q, rx_rst_d;

  logic              w_push;
  ps2_event_t        w_ev;
  logic              w_err_inc;
  logic              w_rst_req;
  logic              w_timeout;
  ps2_event_t        w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  assign w_timeout = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmo_d     = '0;
    kb_ok_d   = kb_ok_q;
    kb_fail_d = kb_fail_q;
    w_push    = 1'b0;
    w_ev      = '0;
    w_err_inc = 1'b0;
    w_rst_req = 1'b0;

    if (!RX_VALID && state_q != ST_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (RX_VALID && RX_ERR) begin
      state_d   = ST_IDLE;
      w_err_inc = 1'b1;
      w_rst_req = 1'b1;
    end else if (RX_VALID) begin
      case (state_q)
        ST_IDLE: begin
          case (RX_DATA)
            c_byte_e0: state_d = ST_E0;
            c_byte_f0: state_d = ST_F0;
            c_byte_e1: begin
              state_d = ST_SKIP;
              skip_d  = c_pause_skip;
            end
            c_byte_aa: begin
              kb_ok_d   = 1'b1;
              kb_fail_d = 1'b0;
            end
            c_byte_fc: begin
              kb_ok_d   = 1'b0;
              kb_fail_d = 1'b1;
              w_rst_req = 1'b1;
            end
            c_byte_00, c_byte_ff: w_err_inc = 1'b1;
            default: begin
              w_push = 1'b1;
              w_ev   = mk_event(RX_DATA, 1'b0, 1'b0);
            end
          endcase
        end
        ST_E0: begin
          state_d = ST_IDLE;
          if (RX_DATA == c_byte_f0) begin
            state_d = ST_E0F0;
          end else if (RX_DATA != c_byte_12) begin
            w_push = 1'b1;
            w_ev   = mk_event(RX_DATA, 1'b1, 1'b0);
          end
        end
        ST_F0: begin
          state_d = ST_IDLE;
          w_push  = 1'b1;
          w_ev    = mk_event(RX_DATA, 1'b0, 1'b1);
        end
        ST_E0F0: begin
          state_d = ST_IDLE;
          if (RX_DATA != c_byte_12) begin
            w_push = 1'b1;
            w_ev   = mk_event(RX_DATA, 1'b1, 1'b1);
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          // The pause key reports once, after its whole 8-byte sequence
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
            w_push  = 1'b1;
            w_ev    = mk_event(c_byte_e1, 1'b1, 1'b0);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      state_d   = ST_IDLE;
      w_err_inc = 1'b1;
      w_rst_req = 1'b1;
    end

    err_cnt_d = (w_err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    rx_rst_d  = w_rst_req && !rx_rst_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      kb_ok_q   <= 1'b0;
      kb_fail_q <= 1'b0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      rx_rst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      kb_ok_q   <= kb_ok_d;
      kb_fail_q <= kb_fail_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_q | w_drop;
      rx_rst_q  <= rx_rst_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (w_push),
    .data_i  (w_ev),
    .pop_i   (EV_READY),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .drop_o  (w_drop)
  );

  assign EV_VALID = !w_empty;
  assign EV_CODE  = w_head.code;
  assign EV_EXT   = w_head.ext;
  assign EV_BREAK = w_head.brk;
  assign KB_OK    = kb_ok_q;
  assign KB_FAIL  = kb_fail_q;
  assign ERR_CNT  = err_cnt_q;
  assign OVF      = ovf_q;
  assign RX_RST   = rx_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_ctrl
// Brief    : Self-checking bench for ps2_key_ctrl. Revision : 1.0
// ============================================================================
module tb_ps2_key_ctrl;

  localparam int TMO   = 40;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       RX_ERR;
  logic       RX_RST;
  logic       EV_VALID;
  logic       EV_READY;
  logic [7:0] EV_CODE;
  logic       EV_EXT;
  logic       EV_BREAK;
  logic       KB_OK;
  logic       KB_FAIL;
  logic [7:0] ERR_CNT;
  logic       OVF;

  int         tests = 0;
  int         fails = 0;
  logic [9:0] exp_q[$];
  logic [7:0] err_exp;

  typedef struct {
    logic [63:0] seq;
    int          nb;
    logic [19:0] ev;
    int          nev;
    int          err_inc;
  } vec_t;

  vec_t vt[12];

  ps2_key_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_VALID (RX_VALID),
    .RX_DATA  (RX_DATA),
    .RX_ERR   (RX_ERR),
    .RX_RST   (RX_RST),
    .EV_VALID (EV_VALID),
    .EV_READY (EV_READY),
    .EV_CODE  (EV_CODE),
    .EV_EXT   (EV_EXT),
    .EV_BREAK (EV_BREAK),
    .KB_OK    (KB_OK),
    .KB_FAIL  (KB_FAIL),
    .ERR_CNT  (ERR_CNT),
    .OVF      (OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] E(input logic [7:0] c, input logic x, input logic b);
    return {c, x, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One byte over two cycles; RX_RST must match rst_exp in n+1 and be low in n+2
  task automatic send(input logic [7:0] b, input logic e, input logic rst_exp);
    RX_DATA  = b;
    RX_ERR   = e;
    RX_VALID = 1'b1;
    cycles(1);
    RX_VALID = 1'b0;
    RX_ERR   = 1'b0;
    check("rx_rst_pulse", RX_RST, rst_exp);
    cycles(1);
    check("rx_rst_low", RX_RST, 0);
  endtask

  // Scoreboard: every handshake compared against the oldest expected event
  always @(negedge CLK) begin
    if (!RST && EV_VALID && EV_READY) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got %h expected none", {EV_CODE, EV_EXT, EV_BREAK});
      end else begin
        check("event", {22'd0, EV_CODE, EV_EXT, EV_BREAK}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{64'h16F016,           3, {E(8'h16,0,1), E(8'h16,0,0)}, 2, 0};
    vt[1]  = '{64'h75E0,             2, {10'h0, E(8'h75,1,0)},        1, 0};
    vt[2]  = '{64'h75F0E0,           3, {10'h0, E(8'h75,1,1)},        1, 0};
    vt[3]  = '{64'h12E0,             2, 20'h0,                        0, 0};
    vt[4]  = '{64'h12F0E0,           3, 20'h0,                        0, 0};
    vt[5]  = '{64'h1C,               1, {10'h0, E(8'h1C,0,0)},        1, 0};
    vt[6]  = '{64'h77F014F0E17714E1, 8, {10'h0, E(8'hE1,1,0)},        1, 0};
    vt[7]  = '{64'h00,               1, 20'h0,                        0, 1};
    vt[8]  = '{64'hFF,               1, 20'h0,                        0, 1};
    vt[9]  = '{64'hF0F0,             2, {10'h0, E(8'hF0,0,1)},        1, 0};
    vt[10] = '{64'hE0E0,             2, {10'h0, E(8'hE0,1,0)},        1, 0};
    vt[11] = '{64'h5A,               1, {10'h0, E(8'h5A,0,0)},        1, 0};

    RST = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00; RX_ERR = 1'b0; EV_READY = 1'b1;
    err_exp = 8'd0;
    cycles(3);
    RST = 1'b0;
    check("reset_outputs",
          {RX_RST, EV_VALID, EV_CODE, EV_EXT, EV_BREAK, KB_OK, KB_FAIL, ERR_CNT, OVF}, 0);

    // Make latency: EV_VALID low during the byte cycle, high the cycle after
    exp_q.push_back(E(8'h16, 0, 0));
    RX_DATA = 8'h16; RX_VALID = 1'b1;
    @(negedge CLK);
    check("latency_before", EV_VALID, 0);
    cycles(1);
    RX_VALID = 1'b0;
    @(negedge CLK);
    check("latency_after", EV_VALID, 1);
    cycles(2);

    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < vt[v].nev; k++) exp_q.push_back(vt[v].ev[10*k +: 10]);
      for (int k = 0; k < vt[v].nb; k++) send(vt[v].seq[8*k +: 8], 1'b0, 1'b0);
      err_exp = err_exp + 8'(vt[v].err_inc);
      cycles(3);
      check($sformatf("vec%0d_err_cnt", v), ERR_CNT, err_exp);
      check($sformatf("vec%0d_drained", v), exp_q.size(), 0);
    end

    // BAT results
    send(8'hAA, 1'b0, 1'b0);
    check("aa_status", {KB_OK, KB_FAIL}, 2'b10);
    send(8'hFC, 1'b0, 1'b1);
    check("fc_status", {KB_OK, KB_FAIL}, 2'b01);
    send(8'hAA, 1'b0, 1'b0);
    check("aa_again_status", {KB_OK, KB_FAIL}, 2'b10);

    // Receive error while in F0 drops the partial code
    send(8'hF0, 1'b0, 1'b0);
    send(8'h1C, 1'b1, 1'b1);
    err_exp = err_exp + 8'd1;
    check("rxerr_err_cnt", ERR_CNT, err_exp);
    exp_q.push_back(E(8'h1C, 0, 0));
    send(8'h1C, 1'b0, 1'b0);

    // Prefix timeout
    send(8'hE0, 1'b0, 1'b0);
    cycles(TMO - 3);
    check("tmo_early_err", ERR_CNT, err_exp);
    check("tmo_early_rst", RX_RST, 0);
    cycles(2);
    err_exp = err_exp + 8'd1;
    check("tmo_rst", RX_RST, 1);
    check("tmo_err_cnt", ERR_CNT, err_exp);
    cycles(1);
    check("tmo_rst_low", RX_RST, 0);
    exp_q.push_back(E(8'h75, 0, 0));
    send(8'h75, 1'b0, 1'b0);

    // Receive error landing on the timeout cycle counts once
    send(8'hE0, 1'b0, 1'b0);
    cycles(TMO - 2);
    send(8'h00, 1'b1, 1'b1);
    err_exp = err_exp + 8'd1;
    cycles(2);
    check("coincide_err_cnt", ERR_CNT, err_exp);
    check("coincide_rst_low", RX_RST, 0);

    // FIFO pressure
    EV_READY = 1'b0;
    send(8'h15, 1'b0, 1'b0); exp_q.push_back(E(8'h15, 0, 0));
    send(8'h1D, 1'b0, 1'b0); exp_q.push_back(E(8'h1D, 0, 0));
    send(8'h24, 1'b0, 1'b0); exp_q.push_back(E(8'h24, 0, 0));
    send(8'h2D, 1'b0, 1'b0); exp_q.push_back(E(8'h2D, 0, 0));
    check("full_ovf", OVF, 0);
    check("full_head", {EV_VALID, EV_CODE}, {1'b1, 8'h15});
    exp_q.push_back(E(8'h3C, 0, 0));
    RX_DATA = 8'h3C; RX_VALID = 1'b1; EV_READY = 1'b1;
    cycles(1);
    RX_VALID = 1'b0; EV_READY = 1'b0;
    cycles(1);
    check("pushpop_ovf", OVF, 0);
    check("pushpop_head", EV_CODE, 8'h1D);
    send(8'h2C, 1'b0, 1'b0);
    check("drop_ovf", OVF, 1);
    send(8'h35, 1'b0, 1'b0);
    EV_READY = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycles(1);
    cycles(1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_hold", {EV_VALID, EV_CODE}, {1'b0, 8'h3C});

    // Reset between E0 and F0
    send(8'hE0, 1'b0, 1'b0);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    err_exp = 8'd0;
    check("midrst_outputs",
          {RX_RST, EV_VALID, EV_CODE, EV_EXT, EV_BREAK, KB_OK, KB_FAIL, ERR_CNT, OVF}, 0);
    exp_q.push_back(E(8'h75, 0, 0));
    send(8'h75, 1'b0, 1'b0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycles(1);
    check("final_drained", exp_q.size(), 0);
    check("final_err_cnt", ERR_CNT, err_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
